// File: rtl/maze_pkg.sv
// Shared direction encodings, walker state type and direction helpers for the maze walker.
package maze_pkg;

  localparam logic [3:0] DIR_UP    = 4'b1000;
  localparam logic [3:0] DIR_DOWN  = 4'b0100;
  localparam logic [3:0] DIR_LEFT  = 4'b0010;
  localparam logic [3:0] DIR_RIGHT = 4'b0001;
  localparam logic [3:0] DIR_NONE  = 4'b0000;

  typedef enum logic {CENTER, MOVE} walker_state_t;

  function automatic logic [3:0] opposite_dir(input logic [3:0] d);
    logic [3:0] o;
    case (d)
      DIR_UP:    o = DIR_DOWN;
      DIR_DOWN:  o = DIR_UP;
      DIR_LEFT:  o = DIR_RIGHT;
      DIR_RIGHT: o = DIR_LEFT;
      default:   o = DIR_NONE;
    endcase
    return o;
  endfunction

  function automatic logic is_onehot4(input logic [3:0] d);
    return (d != 4'd0) && ((d & (d - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/tile_step.sv
// Neighbouring tile coordinate in a given direction, wrapping at the grid edges (tunnels).
module tile_step
  import maze_pkg::*;
#(
  parameter int unsigned GRID_W  = 12,
  parameter int unsigned GRID_H  = 12,
  parameter int unsigned COORD_W = 5
) (
  input  logic [COORD_W-1:0] x_i,
  input  logic [COORD_W-1:0] y_i,
  input  logic [3:0]         dir_i,
  output logic [COORD_W-1:0] x_o,
  output logic [COORD_W-1:0] y_o
);

  localparam logic [COORD_W-1:0] One  = COORD_W'(1);
  localparam logic [COORD_W-1:0] MaxX = COORD_W'(GRID_W);
  localparam logic [COORD_W-1:0] MaxY = COORD_W'(GRID_H);

  always_comb begin
    x_o = x_i;
    y_o = y_i;
    case (dir_i)
      DIR_UP:    y_o = (y_i == One)  ? MaxY : y_i - One;
      DIR_DOWN:  y_o = (y_i == MaxY) ? One  : y_i + One;
      DIR_LEFT:  x_o = (x_i == One)  ? MaxX : x_i - One;
      DIR_RIGHT: x_o = (x_i == MaxX) ? One  : x_i + One;
      default: ;
    endcase
  end

endmodule

// File: rtl/maze_walker.sv
// Tile-grid movement controller: buffers direction requests and decides turn/continue/stop
// at each tile centre, with mid-tile reversal and edge wrap-around.
module maze_walker
  import maze_pkg::*;
#(
  parameter int unsigned GRID_W         = 12,
  parameter int unsigned GRID_H         = 12,
  parameter int unsigned COORD_W        = 5,
  parameter int unsigned STEPS_PER_TILE = 8,
  parameter int unsigned START_X        = 1,
  parameter int unsigned START_Y        = 1,
  localparam int unsigned SUB_W         = (STEPS_PER_TILE > 1) ? $clog2(STEPS_PER_TILE) : 1
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               tick,
  input  logic [3:0]         dir_req,
  input  logic [3:0]         turnable_in,
  output logic [COORD_W-1:0] tile_x,
  output logic [COORD_W-1:0] tile_y,
  output logic [SUB_W-1:0]   sub_step,
  output logic [3:0]         heading,
  output logic               moving,
  output logic               tile_arrive
);

  localparam logic [SUB_W:0]   StepsFull = (SUB_W + 1)'(STEPS_PER_TILE);
  localparam logic [SUB_W-1:0] LastStep  = SUB_W'(STEPS_PER_TILE - 1);

  walker_state_t      state_q, state_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic [SUB_W-1:0]   sub_q, sub_d;
  logic [3:0]         head_q, head_d, req_q, req_d;
  logic               moving_q, moving_d, arrive_q, arrive_d;

  logic               req_valid;
  logic [3:0]         req_eff;
  logic [COORD_W-1:0] nx, ny;

  tile_step #(
    .GRID_W (GRID_W),
    .GRID_H (GRID_H),
    .COORD_W(COORD_W)
  ) u_tile_step (
    .x_i  (x_q),
    .y_i  (y_q),
    .dir_i(head_q),
    .x_o  (nx),
    .y_o  (ny)
  );

  // A valid request arriving with the tick takes part in that tick's decision.
  assign req_valid = is_onehot4(dir_req);
  assign req_eff   = req_valid ? dir_req : req_q;

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    sub_d    = sub_q;
    head_d   = head_q;
    req_d    = req_valid ? dir_req : req_q;
    arrive_d = 1'b0;
    if (tick) begin
      case (state_q)
        CENTER: begin
          if (req_eff != DIR_NONE && (turnable_in & req_eff) != DIR_NONE) begin
            head_d  = req_eff;
            req_d   = DIR_NONE;
            sub_d   = SUB_W'(1);
            state_d = MOVE;
          end else if (head_q != DIR_NONE && (turnable_in & head_q) != DIR_NONE) begin
            sub_d   = SUB_W'(1);
            state_d = MOVE;
          end
        end
        MOVE: begin
          if (req_eff != DIR_NONE && req_eff == opposite_dir(head_q)) begin
            // Re-anchor on the tile ahead so the screen position does not jump.
            head_d = req_eff;
            req_d  = DIR_NONE;
            x_d    = nx;
            y_d    = ny;
            sub_d  = SUB_W'(StepsFull - {1'b0, sub_q});
          end else if (sub_q == LastStep) begin
            x_d      = nx;
            y_d      = ny;
            sub_d    = '0;
            arrive_d = 1'b1;
            state_d  = CENTER;
          end else begin
            sub_d = sub_q + SUB_W'(1);
          end
        end
        default: state_d = CENTER;
      endcase
    end
    moving_d = (state_d == MOVE);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= CENTER;
      x_q      <= COORD_W'(START_X);
      y_q      <= COORD_W'(START_Y);
      sub_q    <= '0;
      head_q   <= DIR_NONE;
      req_q    <= DIR_NONE;
      moving_q <= 1'b0;
      arrive_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      sub_q    <= sub_d;
      head_q   <= head_d;
      req_q    <= req_d;
      moving_q <= moving_d;
      arrive_q <= arrive_d;
    end
  end

  assign tile_x      = x_q;
  assign tile_y      = y_q;
  assign sub_step    = sub_q;
  assign heading     = head_q;
  assign moving      = moving_q;
  assign tile_arrive = arrive_q;

endmodule

// File: tb/tb_maze_walker.sv
// Self-checking bench for maze_walker: vector table plus hand-written movement sequences.
module tb_maze_walker;
  import maze_pkg::*;

  localparam int unsigned CW = 5;
  localparam int unsigned SW = 3;

  logic          Clk = 1'b0;
  logic          Reset, tick;
  logic [3:0]    dir_req, turnable_in;
  logic [CW-1:0] tile_x, tile_y;
  logic [SW-1:0] sub_step;
  logic [3:0]    heading;
  logic          moving, tile_arrive;

  maze_walker #(
    .GRID_W(12), .GRID_H(12), .COORD_W(CW), .STEPS_PER_TILE(8), .START_X(1), .START_Y(1)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .tick       (tick),
    .dir_req    (dir_req),
    .turnable_in(turnable_in),
    .tile_x     (tile_x),
    .tile_y     (tile_y),
    .sub_step   (sub_step),
    .heading    (heading),
    .moving     (moving),
    .tile_arrive(tile_arrive)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic [SW-1:0] s;
    logic [3:0]    h;
    logic          m;
    logic          a;
  } exp_t;

  typedef struct {
    logic       rst;
    logic       tk;
    logic [3:0] d;
    logic [3:0] t;
    exp_t       e;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[16];
  int   checks = 0;
  int   errors = 0;

  function automatic exp_t mk(input int x, input int y, input int s, input logic [3:0] h,
                              input logic m, input logic a);
    exp_t e;
    e.x = CW'(x);
    e.y = CW'(y);
    e.s = SW'(s);
    e.h = h;
    e.m = m;
    e.a = a;
    return e;
  endfunction

  task automatic check_out();
    exp_t e, got;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty at check %0d", checks);
      return;
    end
    e   = sb.pop_front();
    got = {tile_x, tile_y, sub_step, heading, moving, tile_arrive};
    if (got !== e) begin
      errors++;
      $display("FAIL step%0d: got x=%0d y=%0d s=%0d h=%b m=%b a=%b want x=%0d y=%0d s=%0d h=%b m=%b a=%b",
               checks, got.x, got.y, got.s, got.h, got.m, got.a,
               e.x, e.y, e.s, e.h, e.m, e.a);
    end
  endtask

  task automatic step(input logic rst, input logic tk, input logic [3:0] d, input logic [3:0] t,
                      input exp_t e);
    @(negedge Clk);
    Reset       = rst;
    tick        = tk;
    dir_req     = d;
    turnable_in = t;
    sb.push_back(e);
    @(posedge Clk);
    #1;
    check_out();
  endtask

  // One full tile of motion: departing tick, six intermediate ticks, arrival tick.
  task automatic travel(input logic [3:0] d, input logic [3:0] t, input int sx, input int sy,
                        input logic [3:0] h, input int nx, input int ny);
    step(1'b0, 1'b1, d, t, mk(sx, sy, 1, h, 1'b1, 1'b0));
    for (int k = 2; k <= 7; k++) step(1'b0, 1'b1, 4'b0, 4'b0, mk(sx, sy, k, h, 1'b1, 1'b0));
    step(1'b0, 1'b1, 4'b0, 4'b0, mk(nx, ny, 0, h, 1'b0, 1'b1));
  endtask

  initial begin
    Reset       = 1'b1;
    tick        = 1'b0;
    dir_req     = 4'b0;
    turnable_in = 4'b0;

    // Reset (winning over tick), idle ticks, ignored requests, then one tile to the right.
    tbl[0]  = '{1'b1, 1'b1, DIR_RIGHT, 4'b1111, mk(1, 1, 0, DIR_NONE, 0, 0)};
    tbl[1]  = '{1'b1, 1'b1, DIR_RIGHT, 4'b1111, mk(1, 1, 0, DIR_NONE, 0, 0)};
    tbl[2]  = '{1'b0, 1'b1, 4'b0000,   4'b0000, mk(1, 1, 0, DIR_NONE, 0, 0)};
    tbl[3]  = '{1'b0, 1'b1, 4'b0000,   4'b0000, mk(1, 1, 0, DIR_NONE, 0, 0)};
    tbl[4]  = '{1'b0, 1'b1, 4'b0000,   4'b0000, mk(1, 1, 0, DIR_NONE, 0, 0)};
    tbl[5]  = '{1'b0, 1'b0, 4'b0000,   4'b0001, mk(1, 1, 0, DIR_NONE, 0, 0)};
    tbl[6]  = '{1'b0, 1'b1, 4'b0101,   4'b1111, mk(1, 1, 0, DIR_NONE, 0, 0)};
    tbl[7]  = '{1'b0, 1'b1, DIR_RIGHT, 4'b0001, mk(1, 1, 1, DIR_RIGHT, 1, 0)};
    for (int k = 2; k <= 7; k++)
      tbl[k + 6] = '{1'b0, 1'b1, 4'b0000, 4'b0000, mk(1, 1, k, DIR_RIGHT, 1, 0)};
    tbl[14] = '{1'b0, 1'b1, 4'b0000,   4'b0000, mk(2, 1, 0, DIR_RIGHT, 0, 1)};
    tbl[15] = '{1'b0, 1'b0, 4'b0000,   4'b0000, mk(2, 1, 0, DIR_RIGHT, 0, 0)};

    for (int i = 0; i < 16; i++) step(tbl[i].rst, tbl[i].tk, tbl[i].d, tbl[i].t, tbl[i].e);

    // Continue right; up is latched mid-tile and taken at the next centre, wrapping y 1 -> 12.
    step(1'b0, 1'b1, 4'b0, 4'b0001, mk(2, 1, 1, DIR_RIGHT, 1, 0));
    step(1'b0, 1'b0, DIR_UP, 4'b0, mk(2, 1, 1, DIR_RIGHT, 1, 0));
    for (int k = 2; k <= 7; k++) step(1'b0, 1'b1, 4'b0, 4'b0, mk(2, 1, k, DIR_RIGHT, 1, 0));
    step(1'b0, 1'b1, 4'b0, 4'b0, mk(3, 1, 0, DIR_RIGHT, 0, 1));
    travel(4'b0, 4'b1001, 3, 1, DIR_UP, 3, 12);

    // Blocked heading stops; non-one-hot request ignored; valid request turns left.
    step(1'b0, 1'b1, 4'b0, 4'b0011, mk(3, 12, 0, DIR_UP, 0, 0));
    step(1'b0, 1'b1, 4'b0101, 4'b0011, mk(3, 12, 0, DIR_UP, 0, 0));
    step(1'b0, 1'b1, DIR_LEFT, 4'b0011, mk(3, 12, 1, DIR_LEFT, 1, 0));

    // Mid-tile reversal at sub_step 5: re-anchor on tile 2, sub_step 3, back to tile 3.
    for (int k = 2; k <= 5; k++) step(1'b0, 1'b1, 4'b0, 4'b0, mk(3, 12, k, DIR_LEFT, 1, 0));
    step(1'b0, 1'b1, DIR_RIGHT, 4'b0, mk(2, 12, 3, DIR_RIGHT, 1, 0));
    for (int k = 4; k <= 7; k++) step(1'b0, 1'b1, 4'b0, 4'b0, mk(2, 12, k, DIR_RIGHT, 1, 0));
    step(1'b0, 1'b1, 4'b0, 4'b0, mk(3, 12, 0, DIR_RIGHT, 0, 1));

    // Left with a perpendicular request buffered (blocked), then x wraps 1 -> 12.
    step(1'b0, 1'b1, DIR_LEFT, DIR_LEFT, mk(3, 12, 1, DIR_LEFT, 1, 0));
    step(1'b0, 1'b1, 4'b0, 4'b0, mk(3, 12, 2, DIR_LEFT, 1, 0));
    step(1'b0, 1'b1, DIR_UP, 4'b0, mk(3, 12, 3, DIR_LEFT, 1, 0));
    for (int k = 4; k <= 7; k++) step(1'b0, 1'b1, 4'b0, 4'b0, mk(3, 12, k, DIR_LEFT, 1, 0));
    step(1'b0, 1'b1, 4'b0, 4'b0, mk(2, 12, 0, DIR_LEFT, 0, 1));
    travel(4'b0, DIR_LEFT, 2, 12, DIR_LEFT, 1, 12);
    travel(4'b0, DIR_LEFT, 1, 12, DIR_LEFT, 12, 12);

    // Right wraps x 12 -> 1, down wraps y 12 -> 1, then a closed centre stops.
    travel(DIR_RIGHT, DIR_RIGHT, 12, 12, DIR_RIGHT, 1, 12);
    travel(DIR_DOWN, DIR_DOWN, 1, 12, DIR_DOWN, 1, 1);
    step(1'b0, 1'b1, 4'b0, 4'b0, mk(1, 1, 0, DIR_DOWN, 0, 0));

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: %0d entries, want 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
